// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO's combinational-read
// port and re-presents them on a registered valid/ready stream. A main
// register plus one skid register absorb the single extra pop that can occur
// after out_ready drops, so fifo_read_en never depends on out_ready.
module fifo_stream_reader #(
    parameter int BIT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [BIT_WIDTH-1:0] fifo_read_data,
    output logic                 fifo_read_en,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] pop_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic                   main_valid_reg, main_valid_next;
    logic [BIT_WIDTH-1:0]   main_data_reg, main_data_next;
    logic [BIT_WIDTH-1:0]   skid_data_reg, skid_data_next;
    logic                   busy_reg;
    logic [CNT_WIDTH-1:0]   pop_count_reg;
    logic                   fire;

    // Pop whenever the FIFO has data and there is room; rst and flush block it.
    assign fifo_read_en = ~fifo_empty & (state_reg != TWO) & ~flush & ~rst;
    assign fire         = main_valid_reg & out_ready;

    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign busy      = busy_reg;
    assign pop_count = pop_count_reg;

    // State and buffer registers; reset discards everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
            busy_reg       <= (state_next != EMPTY);
        end
    end

    // Pop counter: one count per popping cycle, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_count_reg <= '0;
        end else if (fifo_read_en) begin
            pop_count_reg <= pop_count_reg + CNT_WIDTH'(1);
        end
    end

    // Next-state and buffer update; main always holds the oldest word and
    // main_data is zeroed whenever main becomes invalid.
    always_comb begin
        state_next      = state_reg;
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
            // flush wins over fire: whatever is shown this cycle is dropped
            state_next      = EMPTY;
            main_valid_next = 1'b0;
            main_data_next  = '0;
            skid_data_next  = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (fifo_read_en) begin
                        state_next      = ONE;
                        main_valid_next = 1'b1;
                        main_data_next  = fifo_read_data;
                    end
                end
                ONE: begin
                    if (fifo_read_en && fire) begin
                        main_data_next = fifo_read_data;
                    end else if (fifo_read_en) begin
                        state_next     = TWO;
                        skid_data_next = fifo_read_data;
                    end else if (fire) begin
                        state_next      = EMPTY;
                        main_valid_next = 1'b0;
                        main_data_next  = '0;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state_next     = ONE;
                        main_data_next = skid_data_reg;
                        skid_data_next = '0;
                    end
                end
                default: begin
                    state_next      = EMPTY;
                    main_valid_next = 1'b0;
                    main_data_next  = '0;
                    skid_data_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural FIFO feeding the DUT, a
// scoreboard queue of expected words filled by the stimulus, and a negedge
// monitor that pops and compares on every accepted output word.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       fifo_empty;
    logic [7:0] fifo_read_data;
    logic       out_ready;

    logic        fifo_read_en, out_valid, busy;
    logic [7:0]  out_data;
    logic [15:0] pop_count;

    logic       fifo_read_en4, out_valid4, busy4;
    logic [7:0] out_data4;
    logic [3:0] pop_count4;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       gate_empty = 1'b0;
    logic       gap_phase = 1'b0;
    logic [7:0] exp_word;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_nonempty = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.BIT_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_read_en(fifo_read_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pop_count(pop_count), .busy(busy)
    );

    fifo_stream_reader #(.BIT_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_read_en(fifo_read_en4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .pop_count(pop_count4), .busy(busy4)
    );

    task automatic refresh();
        fifo_empty     = gate_empty || (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        refresh();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
    endtask

    // Behavioural FIFO: pop the head when the DUT strobed read_en at the edge.
    always @(posedge clk) begin : fifo_model
        logic did_pop;
        did_pop = fifo_read_en;
        #1;
        if (did_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    end

    // Monitor: scoreboard compare on accepted words plus protocol rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_empty) check("no_pop_when_empty", {31'd0, fifo_read_en}, 32'd0);
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (gap_phase) check("gap_valid", {31'd0, out_valid}, {31'd0, prev_nonempty});
            if (!out_valid) check("idle_data_zero", {24'd0, out_data}, 32'd0);
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    $display("xfer t=%0t data=%02h expected=%02h pop_count=%0d", $time, out_data, exp_word, pop_count);
                    check("stream_data", {24'd0, out_data}, {24'd0, exp_word});
                end
            end
        end
        prev_stall    = !rst && out_valid && !out_ready && !flush;
        prev_data     = out_data;
        prev_nonempty = !fifo_empty && !flush;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        refresh();

        // Reset / idle with a non-empty FIFO
        for (int v = 8'h11; v <= 8'h18; v++) push(8'(v));
        repeat (3) begin
            @(negedge clk);
            check("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
            check("rst_read_en4", {31'd0, fifo_read_en4}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_data", {24'd0, out_data}, 32'd0);
            check("rst_pop_count", {16'd0, pop_count}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #2 rst = 1'b0;

        // Streaming 0x11..0x18
        @(negedge clk);
        check("first_pop_en", {31'd0, fifo_read_en}, 32'd1);
        check("first_pop_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        check("stream_busy_end", {31'd0, busy}, 32'd0);
        check("stream_valid_end", {31'd0, out_valid}, 32'd0);
        check("stream_pop_count", {16'd0, pop_count}, 32'd8);

        // Backpressure 0xA0..0xA5
        @(posedge clk); #2;
        for (int v = 8'hA0; v <= 8'hA5; v++) push(8'(v));
        @(posedge clk);
        @(posedge clk); #2 out_ready = 1'b0;
        @(negedge clk);
        check("bp_hold_data", {24'd0, out_data}, 32'hA1);
        check("bp_skid_pop", {31'd0, fifo_read_en}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_pop", {31'd0, fifo_read_en}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        check("bp_pop_count", {16'd0, pop_count}, 32'd11);
        @(posedge clk); #2 out_ready = 1'b1;
        @(negedge clk);
        check("bp_two_no_pop", {31'd0, fifo_read_en}, 32'd0);
        @(negedge clk);
        check("bp_recovery_pop", {31'd0, fifo_read_en}, 32'd1);
        wait_drain();
        check("bp_pop_total", {16'd0, pop_count}, 32'd14);

        // Empty boundary: FIFO empty flag toggles every cycle
        @(posedge clk); #2;
        gap_phase = 1'b1;
        for (int v = 8'hC0; v <= 8'hC3; v++) push(8'(v));
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            gate_empty = ~gate_empty;
            refresh();
        end
        gate_empty = 1'b0;
        refresh();
        wait_drain();
        gap_phase = 1'b0;
        check("gap_pop_total", {16'd0, pop_count}, 32'd18);

        // Flush in state TWO holding 0x55, 0x66
        @(posedge clk); #2 out_ready = 1'b0;
        push(8'h55);
        push(8'h66);
        @(posedge clk);
        @(posedge clk); #2 push(8'h77);
        @(negedge clk);
        check("two_busy", {31'd0, busy}, 32'd1);
        check("two_no_pop", {31'd0, fifo_read_en}, 32'd0);
        check("two_main", {24'd0, out_data}, 32'h55);
        @(posedge clk); #2;
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_no_pop", {31'd0, fifo_read_en}, 32'd0);
        @(posedge clk); #2;
        flush = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_pop_count", {16'd0, pop_count}, 32'd20);
        wait_drain();
        check("flush_pop_total", {16'd0, pop_count}, 32'd21);

        // Reset asserted mid-operation discards buffered words at once
        @(posedge clk); #2 out_ready = 1'b0;
        push(8'h90);
        push(8'h91);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", {24'd0, out_data}, 32'd0);
        check("midrst_pop_count", {16'd0, pop_count}, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        refresh();
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;

        // Counter wrap on the 4-bit instance: 15, then 0, then 1
        for (int v = 1; v <= 15; v++) push(8'(v));
        wait_drain();
        check("wrap_cnt4_15", {28'd0, pop_count4}, 32'd15);
        check("wrap_cnt16_15", {16'd0, pop_count}, 32'd15);
        @(posedge clk); #2 push(8'h10);
        wait_drain();
        check("wrap_cnt4_0", {28'd0, pop_count4}, 32'd0);
        check("wrap_cnt16_16", {16'd0, pop_count}, 32'd16);
        @(posedge clk); #2 push(8'h11);
        wait_drain();
        check("wrap_cnt4_1", {28'd0, pop_count4}, 32'd1);
        check("wrap_cnt16_17", {16'd0, pop_count}, 32'd17);
        @(negedge clk);
        check("end_busy4", {31'd0, busy4}, 32'd0);
        check("end_valid4", {31'd0, out_valid4}, 32'd0);
        check("end_data4", {24'd0, out_data4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the team's synchronous FIFO. It pops words through the FIFO's combinational-read port (read_en, read_data, fifo_empty) and presents them on a registered valid/ready output stream for downstream datapath stages. A two-entry output buffer sustains one word per cycle without any combinational path from out_ready to fifo_read_en. A pop counter supports debug and verification.

## Interface
- BIT_WIDTH, 8, data word width; must match the attached FIFO.
- CNT_WIDTH, 16, width of the pop counter.

- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of buffered words
- fifo_empty  input  1  FIFO empty flag
- fifo_read_data  input  BIT_WIDTH  FIFO head word, valid when fifo_empty=0
- fifo_read_en  output  1  FIFO pop strobe
- out_valid  output  1  output word valid
- out_data  output  BIT_WIDTH  output word
- out_ready  input  1  downstream accept
- pop_count  output  CNT_WIDTH  total words popped since reset
- busy  output  1  high when any word is buffered

## Operation
- Buffer: main register (main_valid, main_data) drives out_valid/out_data directly. Skid register (skid_valid, skid_data) holds one overflow word.
- States: EMPTY (no words), ONE (main valid), TWO (main and skid valid).
- fifo_read_en = ~fifo_empty & (state != TWO) & ~flush & ~rst.
  - A pop captures fifo_read_data at the same clock edge.
- fire = out_valid & out_ready.
- EMPTY:
  - pop -> ONE, main <= FIFO word.
  - No pop -> stay in EMPTY.
- ONE:
  - pop & fire -> ONE, main <= FIFO word.
  - pop & ~fire -> TWO, skid <= FIFO word.
  - ~pop & fire -> EMPTY.
  - ~pop & ~fire -> hold.
- TWO (no pop possible):
  - fire -> ONE, main <= skid.
  - ~fire -> hold.
- Ordering is strictly FIFO. Main always holds the oldest buffered word.
- out_data is 0 whenever out_valid=0.
- Stall rule: once out_valid=1 with out_ready=0, out_valid and out_data hold stable until accepted.
- pop_count increments by 1 on every cycle with fifo_read_en=1. It wraps modulo 2^CNT_WIDTH (all-ones -> 0).
- busy = (state != EMPTY).
- flush: next state EMPTY, main and skid invalidated, no pop that cycle. pop_count is unchanged.
  - flush overrides fire; any word shown that cycle counts as discarded even if out_ready=1.
- The block never pops while fifo_empty=1, so it can never cause FIFO underflow.

## Timing
- Reset values (asynchronous): state EMPTY, out_valid 0, out_data 0, skid cleared, pop_count 0, busy 0, fifo_read_en 0.
- Reset asserted mid-operation discards buffered words immediately. fifo_read_en is forced 0 for as long as rst is high.
- Latency: a word at the FIFO head with fifo_empty=0 at cycle n is popped at edge n. It appears on out_valid/out_data in cycle n+1 (state EMPTY or ONE-with-fire).
- Throughput: 1 word/cycle sustained while FIFO is non-empty and out_ready=1.
- Backpressure: after out_ready drops, at most one further pop occurs (into skid), then fifo_read_en stays 0.
- Recovery: when out_ready returns, the skid word is presented the next cycle and popping resumes that same cycle (state ONE).
- Outputs out_valid, out_data, pop_count and busy are register-driven.
- fifo_read_en is combinational from fifo_empty, state, flush and rst only. It is independent of out_ready.

## Test plan
- Reset/idle: hold rst 3 cycles with fifo_empty=0 -> fifo_read_en=0, out_valid=0, out_data=0, pop_count=0. After release -> first pop on the next edge.
- Streaming: FIFO preloaded with 0x11..0x18 and out_ready=1 constant -> outputs 0x11..0x18 on 8 consecutive cycles starting 1 cycle after the first pop; pop_count=8; busy returns 0 after the last accept.
- Backpressure: stream 0xA0..0xA5, drop out_ready for 4 cycles after 0xA1 is presented -> out_data holds 0xA1; exactly one extra pop (0xA2 into skid); then on out_ready=1 -> 0xA1, 0xA2, 0xA3... in order with no loss or duplication.
- Empty boundary: FIFO toggles empty every other cycle -> fifo_read_en never asserted while fifo_empty=1; out_valid gaps match FIFO gaps.
- Flush: in state TWO (words 0x55, 0x66 buffered), assert flush with out_ready=1 -> next cycle out_valid=0, busy=0, no pop in flush cycle, pop_count unchanged.
- Counter wrap: CNT_WIDTH=4, pop 17 words -> pop_count sequence reaches 15 then 0, ending at 1.
